// File: rtl/life_grid_renderer_if.sv
// Cell-store read port and VGA plot port between the Life renderer and its neighbours.
// Both strobes are valid-only: no ready/backpressure, the receiver must accept every cycle.
interface life_grid_renderer_if;
    logic       cell_rd;
    logic [7:0] cell_raddr_x;
    logic [6:0] cell_raddr_y;
    logic       cell_rdata;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;

    modport master (
        output cell_rd, cell_raddr_x, cell_raddr_y, x, y, colour, writeEn,
        input  cell_rdata
    );

    modport slave (
        input  cell_rd, cell_raddr_x, cell_raddr_y, x, y, colour, writeEn,
        output cell_rdata
    );
endinterface

// File: rtl/life_grid_renderer.sv
// Raster-scans the Life cell store and streams one colour-mapped pixel per cell to the adapter.
// Pipe: address issue -> cell_rdata returns -> registered pixel write (read-to-plot latency 2).
module life_grid_renderer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [2:0]                  alive_colour,
    input  logic [2:0]                  dead_colour,
    life_grid_renderer_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  dbg_state
);
    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       drain_cnt;
    logic       rd_en;
    logic       last_addr;
    logic       kill;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic [2:0] alive_q;
    logic [2:0] dead_q;
    logic       p_valid;
    logic [7:0] p_x;
    logic [6:0] p_y;
    logic       px_we;
    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_colour;

    assign last_addr = (rd_x == X_LAST) && (rd_y == Y_LAST);
    // Abort only matters while a frame is in flight; in IDLE/DONE it is ignored.
    assign kill      = abort && ((state == SCAN) || (state == DRAIN));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = SCAN;
            SCAN: begin
                if (abort)          state_nxt = IDLE;
                else if (last_addr) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)          state_nxt = IDLE;
                else if (drain_cnt) state_nxt = DONE;
            end
            DONE:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en     = (state == SCAN);
        busy      = (state == SCAN) || (state == DRAIN);
        done      = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_x    <= 8'd0;
            rd_y    <= 7'd0;
            alive_q <= 3'd0;
            dead_q  <= 3'd0;
        end else if ((state == IDLE) && start) begin
            rd_x    <= 8'd0;
            rd_y    <= 7'd0;
            alive_q <= alive_colour;
            dead_q  <= dead_colour;
        end else if ((state == SCAN) && !abort && !last_addr) begin
            if (rd_x == X_LAST) begin
                rd_x <= 8'd0;
                rd_y <= rd_y + 7'd1;
            end else begin
                rd_x <= rd_x + 8'd1;
            end
        end
    end

    // Coordinates ride alongside the read so each returned cell lands on its own pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_valid   <= 1'b0;
            p_x       <= 8'd0;
            p_y       <= 7'd0;
            px_we     <= 1'b0;
            px_x      <= 8'd0;
            px_y      <= 7'd0;
            px_colour <= 3'd0;
        end else begin
            p_valid <= rd_en && !kill;
            if (rd_en) begin
                p_x <= rd_x;
                p_y <= rd_y;
            end
            px_we <= p_valid && !kill;
            if (p_valid && !kill) begin
                px_x      <= p_x;
                px_y      <= p_y;
                px_colour <= bus.cell_rdata ? alive_q : dead_q;
            end
        end
    end

    assign bus.cell_rd      = rd_en;
    assign bus.cell_raddr_x = rd_x;
    assign bus.cell_raddr_y = rd_y;
    assign bus.writeEn      = px_we;
    assign bus.x            = px_x;
    assign bus.y            = px_y;
    assign bus.colour       = px_colour;
endmodule

// File: tb/tb_life_grid_renderer.sv
// Directed bench for life_grid_renderer on a 4x3 grid with a small synchronous cell store.
module tb_life_grid_renderer;
    localparam int W = 4;
    localparam int H = 3;

    localparam logic [7:0] EXP_AX  [W*H] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
    localparam logic [6:0] EXP_AY  [W*H] = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1, 7'd1, 7'd2, 7'd2, 7'd2, 7'd2};
    localparam logic [2:0] EXP_COL [W*H] = '{3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0};

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [2:0] alive_colour;
    logic [2:0] dead_colour;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;
    logic [W*H-1:0] cells;

    logic [17:0] exp_q[$];
    int n_checks;
    int n_errors;

    life_grid_renderer_if bus ();

    life_grid_renderer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock        (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .alive_colour (alive_colour),
        .dead_colour  (dead_colour),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cell store: one-cycle synchronous read
    always @(posedge clk) begin
        if (bus.cell_rd)
            bus.cell_rdata <= cells[int'(bus.cell_raddr_y) * W + int'(bus.cell_raddr_x)];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rd"},     32'(bus.cell_rd),      0);
        check_val({tag, "_raddrx"}, 32'(bus.cell_raddr_x), 0);
        check_val({tag, "_raddry"}, 32'(bus.cell_raddr_y), 0);
        check_val({tag, "_we"},     32'(bus.writeEn),      0);
        check_val({tag, "_x"},      32'(bus.x),            0);
        check_val({tag, "_y"},      32'(bus.y),            0);
        check_val({tag, "_colour"}, 32'(bus.colour),       0);
        check_val({tag, "_busy"},   32'(busy),             0);
        check_val({tag, "_done"},   32'(done),             0);
        check_val({tag, "_state"},  32'(dbg_state),        0);
    endtask

    // One frame: start in cycle 0, then optional start pulse, colour change, abort or async reset.
    task automatic run_frame(input int abort_cyc, input int start_cyc, input int col_cyc, input int reset_cyc);
        int last_rd;
        int last_we;
        int done_cyc;
        int n_cyc;
        int idx;
        logic [17:0] exp_px;
        last_rd  = (abort_cyc > 0) ? abort_cyc : W*H;
        last_we  = (abort_cyc > 0) ? abort_cyc : W*H + 2;
        done_cyc = (abort_cyc > 0) ? -1 : W*H + 3;
        n_cyc    = (reset_cyc > 0) ? reset_cyc : W*H + 5;
        for (int i = 0; i <= last_we - 3; i++)
            exp_q.push_back({EXP_AX[i], EXP_AY[i], EXP_COL[i]});

        @(negedge clk);
        alive_colour = 3'b111;
        dead_colour  = 3'b000;
        start        = 1'b1;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            check_val("cell_rd", 32'(bus.cell_rd), int'(c <= last_rd));
            if (c <= last_rd) begin
                idx = c - 1;
                check_val("raddr_x", 32'(bus.cell_raddr_x), 32'(EXP_AX[idx]));
                check_val("raddr_y", 32'(bus.cell_raddr_y), 32'(EXP_AY[idx]));
            end
            check_val("writeEn", 32'(bus.writeEn), int'((c >= 3) && (c <= last_we)));
            if (bus.writeEn && (exp_q.size() > 0)) begin
                exp_px = exp_q.pop_front();
                check_val("pixel", 32'({bus.x, bus.y, bus.colour}), 32'(exp_px));
            end
            check_val("busy", 32'(busy), int'(c <= last_we));
            check_val("done", 32'(done), int'(c == done_cyc));
            if ((c == n_cyc) && (reset_cyc == 0)) begin
                idx = last_we - 3;
                check_val("hold_x",      32'(bus.x),      32'(EXP_AX[idx]));
                check_val("hold_y",      32'(bus.y),      32'(EXP_AY[idx]));
                check_val("hold_colour", 32'(bus.colour), 32'(EXP_COL[idx]));
                check_val("q_empty",     exp_q.size(),    0);
            end
            if (c == start_cyc) start = 1'b1;
            if (c == abort_cyc) abort = 1'b1;
            if (c == col_cyc) begin
                alive_colour = 3'b000;
                dead_colour  = 3'b101;
            end
        end

        if (reset_cyc > 0) begin
            #2 reset_n = 1'b0;
            #1 check_all_zero("async_rst");
            exp_q.delete();
            repeat (3) begin
                @(negedge clk);
                check_all_zero("rst_hold");
            end
            reset_n = 1'b1;
            repeat (2) begin
                @(negedge clk);
                check_val("post_rst_busy", 32'(busy), 0);
                check_val("post_rst_done", 32'(done), 0);
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        cells        = 12'b0100_0000_0010;
        reset_n      = 1'b0;
        start        = 1'b1;
        abort        = 1'b0;
        alive_colour = 3'b111;
        dead_colour  = 3'b000;

        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("idle");
        end

        run_frame(0, 0, 0, 0);    // plain frame
        run_frame(0, 0, 4, 0);    // colour inputs change mid-frame
        run_frame(0, 5, 0, 0);    // start while busy
        run_frame(0, 15, 0, 0);   // start in the DONE cycle
        run_frame(6, 0, 0, 0);    // abort in cycle 6
        run_frame(0, 0, 0, 8);    // async reset in cycle 8
        run_frame(0, 0, 0, 0);    // fresh frame after reset restarts at (0,0)

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
